// File: rtl/tmr_scrub_scheduler.sv
// tmr_scrub_scheduler: round-robin scrub scheduler and saturating mismatch statistics for a TMR voter bank
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   enable_i              capture mismatches and issue new grants when 1
//   clear_i               pulse: clear counters, total, overflow, checker fault and pending bits
//   mismatch_i            per-voter mismatch level from the voter bank
//   mismatch_2nd_i        per-voter second-LUT mismatch level (checker build only)
//   scrub_req_o/idx_o     scrub request and voter index, held until scrub_ack_i
//   scrub_ack_i           refresh logic finished the current scrub
//   pending_o             sticky per-voter "scrub needed" vector
//   rd_idx_i/rd_cnt_o     registered per-voter count readout (out-of-range index reads 0)
//   total_cnt_o           saturating total of served scrubs
//   overflow_o            sticky: a counter reached all-ones
//   checker_fault_o       sticky primary/second checker disagreement
// Optional: define TMR_SCRUB_CHECKER_EN to enable the second-LUT checker path.
module tmr_scrub_scheduler #(
    parameter int  N_VOTERS       = 8,
    parameter int  CNT_WIDTH      = 16,
    parameter int  HOLDOFF_CYCLES = 4,
    localparam int IW             = (N_VOTERS > 1) ? $clog2(N_VOTERS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic [N_VOTERS-1:0]  mismatch_i,
    input  logic [N_VOTERS-1:0]  mismatch_2nd_i,
    output logic                 scrub_req_o,
    output logic [IW-1:0]        scrub_idx_o,
    input  logic                 scrub_ack_i,
    output logic [N_VOTERS-1:0]  pending_o,
    input  logic [IW-1:0]        rd_idx_i,
    output logic [CNT_WIDTH-1:0] rd_cnt_o,
    output logic [CNT_WIDTH-1:0] total_cnt_o,
    output logic                 overflow_o,
    output logic                 checker_fault_o
);
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d, ptr_q, ptr_d, sel;
    logic [HW-1:0]        hold_q, hold_d;
    logic [N_VOTERS-1:0]  det_q, det_any, set_v, pending_q, pending_d;
    logic [CNT_WIDTH-1:0] cnt_q [N_VOTERS];
    logic [CNT_WIDTH-1:0] cnt_d [N_VOTERS];
    logic [CNT_WIDTH-1:0] total_q, total_d, rd_q;
    logic                 ovf_q, ovf_d, fault_q, ack_hit;

`ifdef TMR_SCRUB_CHECKER_EN
    logic [N_VOTERS-1:0] det2_q, diff_q;

    // diff_q remembers last cycle's disagreement so a fault needs two consecutive ones
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            det2_q  <= '0;
            diff_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            det2_q  <= mismatch_2nd_i;
            diff_q  <= det_q ^ det2_q;
            fault_q <= !clear_i && (fault_q || |(diff_q & (det_q ^ det2_q)));
        end
    end

    assign det_any = det_q | det2_q;
`else
    logic unused_2nd;

    assign unused_2nd = ^mismatch_2nd_i;
    assign fault_q    = 1'b0;
    assign det_any    = det_q;
`endif

    always_comb begin
        set_v = det_any & {N_VOTERS{enable_i}};
        // descending scan so the smallest offset from the pointer wins
        sel = ptr_q;
        for (int k = N_VOTERS - 1; k >= 0; k--)
            if (pending_q[IW'((int'(ptr_q) + k) % N_VOTERS)]) sel = IW'((int'(ptr_q) + k) % N_VOTERS);
        ack_hit   = (state_q == S_REQ) && scrub_ack_i;
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        total_d   = total_q;
        ovf_d     = ovf_q;
        if (ack_hit) begin
            pending_d[idx_q] = 1'b0;
            cnt_d[idx_q]     = (cnt_q[idx_q] == '1) ? cnt_q[idx_q] : cnt_q[idx_q] + 1'b1;
            total_d          = (total_q == '1) ? total_q : total_q + 1'b1;
            ovf_d            = ovf_q || (cnt_d[idx_q] == '1) || (total_d == '1);
        end
        // clear overrides the increment; new captures override both clears
        if (clear_i) begin
            pending_d = '0;
            for (int i = 0; i < N_VOTERS; i++) cnt_d[i] = '0;
            total_d = '0;
            ovf_d   = 1'b0;
        end
        pending_d = pending_d | set_v;
        case (state_q)
            S_IDLE: begin
                if (enable_i && |pending_q) begin
                    state_d = S_REQ;
                    idx_d   = sel;
                end
            end
            S_REQ: begin
                if (scrub_ack_i) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                    ptr_d   = (int'(idx_q) == N_VOTERS - 1) ? '0 : idx_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (int'(hold_q) == HOLDOFF_CYCLES - 1) state_d = S_IDLE;
                else hold_d = hold_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            det_q     <= '0;
            pending_q <= '0;
            total_q   <= '0;
            ovf_q     <= 1'b0;
            rd_q      <= '0;
            for (int i = 0; i < N_VOTERS; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            det_q     <= mismatch_i;
            pending_q <= pending_d;
            total_q   <= total_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            rd_q      <= (int'(rd_idx_i) < N_VOTERS) ? cnt_q[rd_idx_i] : '0;
        end
    end

    assign scrub_req_o     = (state_q == S_REQ);
    assign scrub_idx_o     = idx_q;
    assign pending_o       = pending_q;
    assign rd_cnt_o        = rd_q;
    assign total_cnt_o     = total_q;
    assign overflow_o      = ovf_q;
    assign checker_fault_o = fault_q;
endmodule
